// File: rtl/sdr_pkg.sv
// Constants and sample-word types shared by the receive-side FIFO and the packetizer.
package sdr_pkg;

   localparam int IQ_W          = 16;
   localparam int WORD_W        = 2 * IQ_W;
   localparam int PKT_WORDS_DFLT = 256;

   // I occupies the upper half so a word reads {i_data, q_data} on the wire.
   typedef struct packed {
      logic signed [IQ_W-1:0] i;
      logic signed [IQ_W-1:0] q;
   } iq_word_t;

   function automatic iq_word_t pack_iq(input logic [IQ_W-1:0] i_in,
                                        input logic [IQ_W-1:0] q_in);
      iq_word_t w;
      w.i = i_in;
      w.q = q_in;
      return w;
   endfunction

endpackage

// File: rtl/iq_fifo_ram.sv
// Simple dual-port sample store with a registered read port, shaped for block-RAM inference.
module iq_fifo_ram
   import sdr_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  iq_word_t      wdata_i,
   input  logic [AW-1:0] raddr_i,
   output iq_word_t      rdata_o
);

   iq_word_t mem [DEPTH];

   // NOTE: the array and its read register carry no reset; resetting them would stop block-RAM inference, and the FIFO pointers already mark every location as invalid after reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/iq_sample_fifo.sv
// First-word-fall-through I/Q sample FIFO feeding the packetizer; drops and counts samples on overflow.
module iq_sample_fifo
   import sdr_pkg::*;
#(
   parameter int DEPTH     = 1024,
   parameter int PKT_WORDS = PKT_WORDS_DFLT
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   input  logic                    iq_valid,
   input  logic [IQ_W-1:0]         i_data,
   input  logic [IQ_W-1:0]         q_data,
   input  logic                    rd_en,
   output logic [WORD_W-1:0]       rd_data,
   output logic                    rd_dr,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    ovf,
   output logic                    unf,
   output logic [15:0]             drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] PKT_L   = LW'(PKT_WORDS);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          rd_dr_q, rd_dr_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic [15:0]   drop_q, drop_d;
   logic          byp_sel_q, byp_sel_d;
   iq_word_t      byp_q, byp_d;
   iq_word_t      wr_word, ram_rdata;
   logic          full, empty, wr_acc, rd_acc;

   iq_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_word),
      .raddr_i (rd_ptr_d),
      .rdata_o (ram_rdata)
   );

   // NOTE: every signal assigned in this block gets its default first, so no path through it can infer a latch.
   always_comb begin
      wr_word   = pack_iq(i_data, q_data);
      full      = (level_q == DEPTH_L);
      empty     = (level_q == '0);
      wr_acc    = iq_valid && !full && !flush;
      rd_acc    = rd_en && !empty && !flush;

      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      drop_d    = drop_q;
      byp_sel_d = byp_sel_q;
      byp_d     = byp_q;

      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         ovf_d     = 1'b0;
         unf_d     = 1'b0;
         drop_d    = '0;
         byp_sel_d = 1'b1;
         byp_d     = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + AW'(wr_acc);
         rd_ptr_d = rd_ptr_q + AW'(rd_acc);
         level_d  = level_q + LW'(wr_acc) - LW'(rd_acc);
         ovf_d    = ovf_q | (iq_valid & full);
         unf_d    = unf_q | (rd_en & empty);
         if (iq_valid && full && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
         end
         // The RAM cannot return a word written on this same edge, so the new head comes from the bypass register.
         if (wr_acc) begin
            byp_sel_d = (rd_ptr_d == wr_ptr_q);
            byp_d     = wr_word;
         end else if (level_d != '0) begin
            byp_sel_d = 1'b0;
         end
      end

      rd_dr_d = (level_d >= PKT_L);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         rd_dr_q   <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         drop_q    <= '0;
         byp_sel_q <= 1'b1;
         byp_q     <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         rd_dr_q   <= rd_dr_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         drop_q    <= drop_d;
         byp_sel_q <= byp_sel_d;
         byp_q     <= byp_d;
      end
   end

   // Head word selects between two registers under a registered select; no input reaches it combinationally.
   assign rd_data  = byp_sel_q ? byp_q : ram_rdata;
   assign rd_dr    = rd_dr_q;
   assign level    = level_q;
   assign ovf      = ovf_q;
   assign unf      = unf_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Directed bench for iq_sample_fifo at DEPTH=8, PKT_WORDS=4.
module tb_iq_sample_fifo;

   localparam int DEPTH = 8;
   localparam int PKT   = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk      = 1'b0;
   logic          rstn     = 1'b0;
   logic          flush    = 1'b0;
   logic          iq_valid = 1'b0;
   logic          rd_en    = 1'b0;
   logic [15:0]   i_data   = '0;
   logic [15:0]   q_data   = '0;
   logic [31:0]   rd_data;
   logic          rd_dr;
   logic [LW-1:0] level;
   logic          ovf;
   logic          unf;
   logic [15:0]   drop_cnt;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] model_q [$];

   always #10 clk = ~clk;

   iq_sample_fifo #(.DEPTH(DEPTH), .PKT_WORDS(PKT)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (flush),
      .iq_valid (iq_valid),
      .i_data   (i_data),
      .q_data   (q_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_dr    (rd_dr),
      .level    (level),
      .ovf      (ovf),
      .unf      (unf),
      .drop_cnt (drop_cnt)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit wr, input bit rd, input logic [31:0] w);
      iq_valid = wr;
      rd_en    = rd;
      i_data   = w[31:16];
      q_data   = w[15:0];
   endtask

   initial begin
      logic [31:0] w;
      logic [15:0] iv;

      // Reset state
      #25;
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_rd_dr", 32'(rd_dr), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_unf", 32'(unf), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Three writes: I=1..3, Q=-1..-3
      drive(1, 0, 32'h0001FFFF);
      tick();
      check("first_word_latency", rd_data, 32'h0001FFFF);
      check("level_after_1", 32'(level), 32'd1);
      drive(1, 0, 32'h0002FFFE);
      tick();
      drive(1, 0, 32'h0003FFFD);
      tick();
      drive(0, 0, 32'h0);
      check("level_after_3", 32'(level), 32'd3);
      check("rd_dr_below_pkt", 32'(rd_dr), 32'd0);
      check("head_after_3", rd_data, 32'h0001FFFF);

      // Fourth write reaches the packet threshold
      drive(1, 0, 32'h0004FFFC);
      tick();
      drive(0, 0, 32'h0);
      check("rd_dr_rise", 32'(rd_dr), 32'd1);
      check("level_after_4", 32'(level), 32'd4);

      // Back-to-back pops of the four words
      for (int k = 0; k < 4; k++) begin
         iv = 16'(k + 1);
         w  = {iv, 16'(-iv)};
         drive(0, 1, 32'h0);
         check("pop_data", rd_data, w);
         tick();
         check("pop_rd_dr", 32'(rd_dr), 32'd0);
         check("pop_level", 32'(level), 32'(3 - k));
      end
      drive(0, 0, 32'h0);

      // Overflow: 11 writes into 8 slots
      for (int k = 0; k < 11; k++) begin
         w = {16'h0010 + 16'(k), 16'(k)};
         if (k < DEPTH) model_q.push_back(w);
         drive(1, 0, w);
         tick();
      end
      drive(0, 0, 32'h0);
      check("ovf_level", 32'(level), 32'd8);
      check("ovf_flag", 32'(ovf), 32'd1);
      check("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
      check("ovf_rd_dr", 32'(rd_dr), 32'd1);

      // Full FIFO with read and write together: write is still dropped
      drive(1, 1, 32'hDEADBEEF);
      check("full_rw_head", rd_data, model_q[0]);
      tick();
      void'(model_q.pop_front());
      drive(0, 0, 32'h0);
      check("full_rw_drop_cnt", 32'(drop_cnt), 32'd4);
      check("full_rw_level", 32'(level), 32'd7);
      check("full_rw_next_head", rd_data, model_q[0]);

      for (int k = 0; k < 2; k++) begin
         drive(0, 1, 32'h0);
         check("pre_hold_data", rd_data, model_q[0]);
         tick();
         void'(model_q.pop_front());
      end
      drive(0, 0, 32'h0);
      check("pre_hold_level", 32'(level), 32'd5);

      // Simultaneous read and write for 10 cycles at level 5
      for (int k = 0; k < 10; k++) begin
         w = 32'h01000000 + 32'(k);
         drive(1, 1, w);
         check("hold_data", rd_data, model_q[0]);
         tick();
         void'(model_q.pop_front());
         model_q.push_back(w);
         check("hold_level", 32'(level), 32'd5);
      end

      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 32'h0);
         check("drain_data", rd_data, model_q[0]);
         tick();
         void'(model_q.pop_front());
      end
      drive(0, 0, 32'h0);
      check("drain_level", 32'(level), 32'd0);
      check("drain_rd_dr", 32'(rd_dr), 32'd0);

      // Underflow then flush
      drive(0, 1, 32'h0);
      tick();
      drive(0, 0, 32'h0);
      check("unf_flag", 32'(unf), 32'd1);
      check("unf_level", 32'(level), 32'd0);
      check("unf_ovf_sticky", 32'(ovf), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_unf", 32'(unf), 32'd0);
      check("flush_ovf", 32'(ovf), 32'd0);
      check("flush_drop", 32'(drop_cnt), 32'd0);
      check("flush_level", 32'(level), 32'd0);

      // Asynchronous reset mid-burst at level 6
      for (int k = 0; k < 6; k++) begin
         drive(1, 0, 32'h02000000 + 32'(k));
         tick();
      end
      check("burst_level", 32'(level), 32'd6);
      check("burst_rd_dr", 32'(rd_dr), 32'd1);
      drive(1, 0, 32'h02000006);
      #5;
      rstn = 1'b0;
      #1;
      check("arst_rd_data", rd_data, 32'h0);
      check("arst_level", 32'(level), 32'd0);
      check("arst_rd_dr", 32'(rd_dr), 32'd0);
      check("arst_ovf", 32'(ovf), 32'd0);
      check("arst_unf", 32'(unf), 32'd0);
      check("arst_drop", 32'(drop_cnt), 32'd0);
      drive(0, 0, 32'h0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      drive(1, 0, 32'h0ABC0123);
      tick();
      drive(0, 0, 32'h0);
      check("post_rst_first", rd_data, 32'h0ABC0123);
      check("post_rst_level", 32'(level), 32'd1);
      tick();
      check("post_rst_hold", rd_data, 32'h0ABC0123);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
